pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencer for the five-stage MIPS pipeline. Each cycle it decides which pipeline registers advance, hold or flush (IF/ID, ID/EX, EX/MEM, MEM/WB) and whether the PC updates. It arbitrates between instruction-cache misses, data-cache waits, load-use hazards, taken branches/jumps and the halt drain. It sits beside the datapath and drives the `en`/flush controls of every pipe interface, including MEM/WB.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters; present only with `PIPELINE_CTRL_PERF_EN`.

Ports:
- `CLK`  in  1  clock; everything is rising-edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ihit`  in  1  instruction fetch completed this cycle.
- `dhit`  in  1  data access completed this cycle.
- `mm_dREN`, `mm_dWEN`  in  1 each  load/store currently in the MEM stage.
- `ex_memread`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register (`regbits_t`) of the EX instruction.
- `id_rs`, `id_rt`  in  5 each  source registers of the ID instruction.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `mm_pcsrc`  in  1  branch taken or jump resolved in MEM.
- `wb_halt`  in  1  halt has reached the MEM/WB output.
- `flush_done`  in  1  data cache writeback complete.
- `pc_en`  out  1  PC register update.
- `ifid_en`, `idex_en`, `exmm_en`, `mmwb_en`  out  1 each  stage register load.
- `ifid_flush`, `idex_flush`, `exmm_flush`  out  1 each  load a bubble (all-zero controls) on the next edge.
- `dcache_flush`  out  1  request a data-cache writeback.
- `halted`  out  1  processor stopped; sticky until reset.
- `stall_cycles`, `flush_events`  out  CNT_W each  performance counters (macro only).

## Operation
States and outputs:
- FSM states: RUN, DWAIT, DRAIN, HALTED. Reset enters RUN.
- Reset forces every output to 0.
- `dreq` = `mm_dREN | mm_dWEN`.
- `lu` (load-use hazard) = `ex_memread & ex_rd != 0 & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt))`.
- Enables are 1 and flushes are 0 unless a rule below says otherwise.

RUN rules, highest priority first:
1. `wb_halt`: all enables 0, all flushes 1, `dcache_flush`=1; go to DRAIN.
2. `dreq & !dhit`: all enables 0, all flushes 0 (full freeze); go to DWAIT.
3. `mm_pcsrc`: PC loads the target; `ifid_flush`, `idex_flush` and `exmm_flush` are 1. This rule overrides `lu` and `!ihit`.
4. `lu`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1; later stages advance.
5. `!ihit`: `pc_en`=0, `ifid_flush`=1; later stages advance.

DWAIT:
- Full freeze while `!dhit`.
- On `dhit`, apply RUN rules 3–5 in the same cycle and return to RUN.
- `wb_halt` is ignored in DWAIT, because MEM/WB is frozen.

DRAIN:
- All enables 0; `dcache_flush` held at 1.
- On `flush_done`, go to HALTED.

HALTED:
- All enables 0, `dcache_flush`=0, `halted`=1.
- Exit only through reset.

## Timing
- Every control output is a combinational function of the current state and inputs, so it acts on the same clock edge. The state register adds no latency.
- The load-use bubble costs exactly 1 cycle. The ID instruction re-evaluates the next cycle with the load now in MEM, so `lu` is false.
- A taken branch costs 3 bubbles, inserted on the edge after `mm_pcsrc`.
- `ihit` and `dhit` in the same cycle as `dreq`: no stall.
- `!ihit` during DWAIT: the freeze holds. On exit, rule 5 applies if `ihit` is still low.
- `RST` asserted mid-DRAIN or mid-DWAIT: immediate return to RUN with outputs 0. Any in-flight cache request is abandoned.
- `halted` rises on the edge after `flush_done`.

## Configuration
`PIPELINE_CTRL_PERF_EN`:
- Defined: the `stall_cycles` and `flush_events` ports and `CNT_W` exist.
  - `stall_cycles` increments on every cycle where `pc_en`=0 while in RUN or DWAIT.
  - `flush_events` increments on each `mm_pcsrc`-driven flush.
  - Both reset to 0, wrap modulo 2^CNT_W, and freeze in DRAIN and HALTED.
- Undefined: the ports, parameter and counters are absent. Control behaviour is identical.

## Structure
- `pctrl_state_t` (the 2-bit FSM enum) belongs in `control_unit_types_pkg`.
- `regbits_t` and `word_t` come from `cpu_types_pkg`.
- One sub-module, `hazard_detect`: the purely combinational `lu` comparator.
- FSM, priority mux and counters stay in `pipeline_ctrl`.

## Test plan
- `ex_memread`=1, `ex_rd`=8, `id_rs`=8 in RUN:
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for 1 cycle, then all enables 1.
  - With `ex_rd`=0: no stall.
- `mm_dREN`=1, `dhit` low for 4 cycles: all enables 0 for 4 cycles, state DWAIT; everything advances on the `dhit` cycle.
- `mm_pcsrc`=1 together with `lu`=1 and `ihit`=0: `pc_en`=1, three flushes 1, `ifid_en`=1; `flush_events` +1 (macro on).
- `wb_halt`=1 and `flush_done` asserted 6 cycles later:
  - `dcache_flush` high for 6 cycles.
  - `halted`=1 from the next edge and stays 1 regardless of inputs.
- `RST` pulsed during DWAIT and during DRAIN: all outputs 0 asynchronously; RUN after release.
- `ihit`=0 for 3 cycles (macro on): `ifid_flush`=1 each cycle; `stall_cycles`=3.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// Control-path types: the pipeline sequencer state encoding.
package control_unit_types_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pctrl_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the five-stage MIPS core.
package cpu_types_pkg;
    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: ID reads a register that the load in EX will write.
// Purely combinational (0 cycles); no flow control of its own.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_memread,
    input  regbits_t ex_rd,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     lu
);
    assign lu = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle advance/hold/flush of all stage registers; controls are same-cycle combinational.
// Backpressure: cache waits freeze the pipe; halt drains the dcache. PIPELINE_CTRL_PERF_EN adds perf counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
`ifdef PIPELINE_CTRL_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mm_dREN,
    input  logic             mm_dWEN,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             mm_pcsrc,
    input  logic             wb_halt,
    input  logic             flush_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmm_en,
    output logic             mmwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmm_flush,
    output logic             dcache_flush,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`else
    output logic             halted
`endif
);
    pctrl_state_t state_q, state_d;
    logic         lu;
    logic         dreq;
    logic         advance;
    logic [4:0]   en_c;      // {pc, ifid, idex, exmm, mmwb}
    logic [2:0]   flush_c;   // {ifid, idex, exmm}
    logic         dcache_flush_c;
    logic         halted_c;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rd      (regbits_t'(ex_rd)),
        .id_rs      (regbits_t'(id_rs)),
        .id_rt      (regbits_t'(id_rt)),
        .id_uses_rt (id_uses_rt),
        .lu         (lu)
    );

    assign dreq = mm_dREN | mm_dWEN;

    always_comb begin
        state_d        = state_q;
        advance        = 1'b0;
        en_c           = 5'b11111;
        flush_c        = 3'b000;
        dcache_flush_c = 1'b0;
        halted_c       = 1'b0;
        case (state_q)
            RUN: begin
                if (wb_halt) begin
                    en_c           = '0;
                    flush_c        = 3'b111;
                    dcache_flush_c = 1'b1;
                    state_d        = DRAIN;
                end else if (dreq && !dhit) begin
                    en_c    = '0;
                    state_d = DWAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            // MEM/WB is frozen here, so a halt cannot be arriving yet
            DWAIT: begin
                if (dhit) begin
                    advance = 1'b1;
                    state_d = RUN;
                end else begin
                    en_c = '0;
                end
            end
            DRAIN: begin
                en_c           = '0;
                dcache_flush_c = 1'b1;
                if (flush_done) begin
                    state_d = HALTED;
                end
            end
            default: begin
                en_c     = '0;
                halted_c = 1'b1;
            end
        endcase

        if (advance) begin
            if (mm_pcsrc) begin
                flush_c = 3'b111;
            end else if (lu) begin
                en_c[4]    = 1'b0;
                en_c[3]    = 1'b0;
                flush_c[1] = 1'b1;
            end else if (!ihit) begin
                en_c[4]    = 1'b0;
                flush_c[2] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset must silence every control immediately, not just on the next edge
    assign {pc_en, ifid_en, idex_en, exmm_en, mmwb_en} = RST ? 5'b00000 : en_c;
    assign {ifid_flush, idex_flush, exmm_flush}         = RST ? 3'b000 : flush_c;
    assign dcache_flush                                 = RST ? 1'b0 : dcache_flush_c;
    assign halted                                       = RST ? 1'b0 : halted_c;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (((state_q == RUN) || (state_q == DWAIT)) && !en_c[4]) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (advance && mm_pcsrc) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif
endmodule
